// File: rtl/uart_reg_if.sv
// uart_reg_if: 16550-style host register front end for the tx_rx UART core.
// Ports: host bus (addr/wr_en/rd_en/wdata/rdata/irq), core config and status.
module uart_reg_if #(
    parameter logic [7:0] DLL_RST   = 8'h01,
    parameter logic [7:0] DLM_RST   = 8'h00,
    parameter int         BUSY_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  addr,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        irq,
    output logic [1:0]  word_length,
    output logic        stop_bits,
    output logic [2:0]  parity,
    output logic        set_break,
    output logic [15:0] baud_rate_cnt,
    output logic [7:0]  pi_tx_data,
    output logic        write_flag,
    output logic        read_flag,
    input  logic [7:0]  po_rx_data,
    input  logic        parity_error,
    input  logic        data_ready,
    input  logic        busy_flag
);

    localparam int CW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        WAIT
    } tx_state_t;

    tx_state_t state, state_nxt;
    logic [CW-1:0] wait_cnt, wait_cnt_nxt;
    logic          wf_nxt;

    logic [7:0] lcr, dll, dlm, scr;
    logic [2:0] ier;
    logic       pe;
    logic       thre_int;
    logic       thre_prev;

    logic       dlab;
    logic       thre, temt;
    logic [7:0] lsr, iir, rd_mux;
    logic       thr_wr, rbr_rd, lsr_rd, iir_rd;

    assign dlab = lcr[7];
    assign thre = (state == IDLE);
    assign temt = thre & ~busy_flag;
    assign lsr  = {1'b0, temt, thre, 2'b00, pe, 1'b0, data_ready};

    assign thr_wr = wr_en & (addr == 3'd0) & ~dlab;
    assign rbr_rd = rd_en & (addr == 3'd0) & ~dlab;
    assign lsr_rd = rd_en & (addr == 3'd5);
    assign iir_rd = rd_en & (addr == 3'd2);

    assign word_length   = lcr[1:0];
    assign stop_bits     = lcr[2];
    assign parity        = lcr[5:3];
    assign set_break     = lcr[6];
    assign baud_rate_cnt = {dlm, dll};

    always_comb begin
        iir = 8'h01;
        if (pe & ier[2])
            iir = 8'h06;
        else if (data_ready & ier[0])
            iir = 8'h04;
        else if (thre_int & ier[1])
            iir = 8'h02;
    end

    // Reads see register values from before any same-cycle write.
    always_comb begin
        rd_mux = 8'h00;
        unique case (addr)
            3'd0:    rd_mux = dlab ? dll : po_rx_data;
            3'd1:    rd_mux = dlab ? dlm : {5'b0, ier};
            3'd2:    rd_mux = iir;
            3'd3:    rd_mux = lcr;
            3'd5:    rd_mux = lsr;
            3'd7:    rd_mux = scr;
            default: rd_mux = 8'h00;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        wf_nxt       = 1'b0;
        unique case (state)
            IDLE: begin
                if (thr_wr)
                    state_nxt = PEND;
            end
            PEND: begin
                if (!busy_flag) begin
                    wf_nxt       = 1'b1;
                    state_nxt    = WAIT;
                    wait_cnt_nxt = '0;
                end
            end
            WAIT: begin
                // Leave once the core shows busy, or give up after BUSY_WAIT cycles.
                if (busy_flag || wait_cnt == CW'(BUSY_WAIT - 1))
                    state_nxt = IDLE;
                else
                    wait_cnt_nxt = wait_cnt + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            lcr        <= 8'h03;
            dll        <= DLL_RST;
            dlm        <= DLM_RST;
            ier        <= 3'b000;
            scr        <= 8'h00;
            rdata      <= 8'h00;
            irq        <= 1'b0;
            write_flag <= 1'b0;
            read_flag  <= 1'b0;
            pi_tx_data <= 8'h00;
            pe         <= 1'b0;
            thre_int   <= 1'b0;
            thre_prev  <= 1'b1;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            write_flag <= wf_nxt;
            read_flag  <= rbr_rd;
            irq        <= ~iir[0];
            thre_prev  <= thre;

            if (rd_en)
                rdata <= rd_mux;

            if (wr_en) begin
                unique case (addr)
                    3'd0:    if (dlab) dll <= wdata;
                    3'd1:    if (dlab) dlm <= wdata; else ier <= wdata[2:0];
                    3'd3:    lcr <= wdata;
                    3'd7:    scr <= wdata;
                    default: ;
                endcase
            end

            // A THR write in WAIT is dropped; in PEND it replaces the byte.
            if (thr_wr && state != WAIT)
                pi_tx_data <= wdata;

            // Set beats the read-clear when both land together.
            pe <= (pe & ~lsr_rd) | (parity_error & data_ready);

            // A THR write both consumes the interrupt and refills the holding reg.
            thre_int <= ((thre_int & ~(iir_rd & iir == 8'h02))
                         | (thre & ~thre_prev)) & ~thr_wr;
        end
    end

endmodule

// File: tb/tb_uart_reg_if.sv
// tb_uart_reg_if: directed self-checking bench for uart_reg_if.
// Ports: none; drives the DUT host bus and a hand-driven core model.
module tb_uart_reg_if;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  addr;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        irq;
    logic [1:0]  word_length;
    logic        stop_bits;
    logic [2:0]  parity;
    logic        set_break;
    logic [15:0] baud_rate_cnt;
    logic [7:0]  pi_tx_data;
    logic        write_flag;
    logic        read_flag;
    logic [7:0]  po_rx_data;
    logic        parity_error;
    logic        data_ready;
    logic        busy_flag;

    int checks = 0;
    int failures = 0;
    int wf_cnt = 0;
    int rf_cnt = 0;

    always #5 clk = ~clk;

    uart_reg_if #(
        .DLL_RST(8'h01),
        .DLM_RST(8'h00),
        .BUSY_WAIT(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .addr(addr),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .wdata(wdata),
        .rdata(rdata),
        .irq(irq),
        .word_length(word_length),
        .stop_bits(stop_bits),
        .parity(parity),
        .set_break(set_break),
        .baud_rate_cnt(baud_rate_cnt),
        .pi_tx_data(pi_tx_data),
        .write_flag(write_flag),
        .read_flag(read_flag),
        .po_rx_data(po_rx_data),
        .parity_error(parity_error),
        .data_ready(data_ready),
        .busy_flag(busy_flag)
    );

    // Count high cycles of the core strobes.
    always @(negedge clk) begin
        if (write_flag) wf_cnt <= wf_cnt + 1;
        if (read_flag)  rf_cnt <= rf_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired");
        $fatal(1, "watchdog");
    end

    // Tasks start and end at a negedge.
    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        addr = a; wdata = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        addr = a; rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        d = rdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [7:0] d;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        rd(3'd3, d);
        checks++;
        if (d !== 8'h03) begin
            failures++;
            $display("FAIL reset_lcr got=%h exp=03", d);
        end
        rd(3'd5, d);
        checks++;
        if (d !== 8'h60) begin
            failures++;
            $display("FAIL reset_lsr got=%h exp=60", d);
        end
        rd(3'd2, d);
        checks++;
        if (d !== 8'h01) begin
            failures++;
            $display("FAIL reset_iir got=%h exp=01", d);
        end
        checks++;
        if ({irq, write_flag, pi_tx_data, baud_rate_cnt} !== {1'b0, 1'b0, 8'h00, 16'h0001}) begin
            failures++;
            $display("FAIL reset_outs got=%b %b %h %h exp=0 0 00 0001",
                     irq, write_flag, pi_tx_data, baud_rate_cnt);
        end
        checks++;
        if ({word_length, stop_bits, parity, set_break} !== {2'd3, 1'b0, 3'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_lcr_outs got=%h %b %h %b exp=3 0 0 0",
                     word_length, stop_bits, parity, set_break);
        end
    endtask

    task automatic test_divisor;
        logic [7:0] d;
        wr(3'd3, 8'h83);
        wr(3'd0, 8'h36);
        wr(3'd1, 8'h01);
        checks++;
        if (baud_rate_cnt !== 16'h0136) begin
            failures++;
            $display("FAIL baud got=%h exp=0136", baud_rate_cnt);
        end
        rd(3'd0, d);
        checks++;
        if (d !== 8'h36 || read_flag !== 1'b0) begin
            failures++;
            $display("FAIL dll_rd got=%h rf=%b exp=36 rf=0", d, read_flag);
        end
        wr(3'd3, 8'h1B);
        checks++;
        if ({word_length, stop_bits, parity, set_break} !== {2'd3, 1'b0, 3'b011, 1'b0}) begin
            failures++;
            $display("FAIL framing got=%h %b %b %b exp=3 0 011 0",
                     word_length, stop_bits, parity, set_break);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d;
        int base;
        busy_flag = 1'b0;
        base = wf_cnt;
        wr(3'd0, 8'hA5);
        checks++;
        if (pi_tx_data !== 8'hA5 || write_flag !== 1'b0) begin
            failures++;
            $display("FAIL tx_latch got=%h wf=%b exp=a5 wf=0", pi_tx_data, write_flag);
        end
        rd(3'd5, d);
        checks++;
        if (d !== 8'h00 || write_flag !== 1'b1) begin
            failures++;
            $display("FAIL tx_pend got lsr=%h wf=%b exp=00 wf=1", d, write_flag);
        end
        busy_flag = 1'b1;
        rd(3'd5, d);
        checks++;
        if (d !== 8'h00 || write_flag !== 1'b0) begin
            failures++;
            $display("FAIL tx_wait got lsr=%h wf=%b exp=00 wf=0", d, write_flag);
        end
        rd(3'd5, d);
        checks++;
        if (d !== 8'h20) begin
            failures++;
            $display("FAIL tx_idle_busy got lsr=%h exp=20", d);
        end
        wr(3'd0, 8'h5A);
        idle(3);
        checks++;
        if (write_flag !== 1'b0 || pi_tx_data !== 8'h5A || wf_cnt - base !== 1) begin
            failures++;
            $display("FAIL tx_held got wf=%b data=%h pulses=%0d exp=0 5a 1",
                     write_flag, pi_tx_data, wf_cnt - base);
        end
        wr(3'd0, 8'hC3);
        checks++;
        if (pi_tx_data !== 8'hC3) begin
            failures++;
            $display("FAIL tx_overwrite got=%h exp=c3", pi_tx_data);
        end
        busy_flag = 1'b0;
        idle(1);
        checks++;
        if (write_flag !== 1'b1) begin
            failures++;
            $display("FAIL tx_release got wf=%b exp=1", write_flag);
        end
        busy_flag = 1'b1;
        idle(1);
        busy_flag = 1'b0;
        idle(4);
        checks++;
        if (wf_cnt - base !== 2 || pi_tx_data !== 8'hC3) begin
            failures++;
            $display("FAIL tx_pulses got=%0d data=%h exp=2 c3", wf_cnt - base, pi_tx_data);
        end
    endtask

    task automatic test_rx_read;
        logic [7:0] d;
        int base;
        po_rx_data = 8'h3C;
        data_ready = 1'b1;
        wr(3'd1, 8'h01);
        rd(3'd2, d);
        checks++;
        if (d !== 8'h04 || irq !== 1'b1) begin
            failures++;
            $display("FAIL rx_iir got=%h irq=%b exp=04 irq=1", d, irq);
        end
        base = rf_cnt;
        rd(3'd0, d);
        checks++;
        if (d !== 8'h3C || read_flag !== 1'b1) begin
            failures++;
            $display("FAIL rx_rbr got=%h rf=%b exp=3c rf=1", d, read_flag);
        end
        data_ready = 1'b0;
        idle(1);
        checks++;
        if (read_flag !== 1'b0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL rx_after got rf=%b irq=%b exp=0 0", read_flag, irq);
        end
        idle(1);
        checks++;
        if (rf_cnt - base !== 1) begin
            failures++;
            $display("FAIL rx_pulses got=%0d exp=1", rf_cnt - base);
        end
    endtask

    task automatic test_parity;
        logic [7:0] d;
        data_ready = 1'b1;
        parity_error = 1'b1;
        wr(3'd1, 8'h05);
        rd(3'd2, d);
        checks++;
        if (d !== 8'h06) begin
            failures++;
            $display("FAIL pe_iir got=%h exp=06", d);
        end
        rd(3'd5, d);
        rd(3'd5, d);
        checks++;
        if (d !== 8'h65) begin
            failures++;
            $display("FAIL pe_set_wins got=%h exp=65", d);
        end
        parity_error = 1'b0;
        rd(3'd5, d);
        checks++;
        if (d !== 8'h65) begin
            failures++;
            $display("FAIL pe_lsr1 got=%h exp=65", d);
        end
        rd(3'd5, d);
        checks++;
        if (d !== 8'h61) begin
            failures++;
            $display("FAIL pe_lsr2 got=%h exp=61", d);
        end
        data_ready = 1'b0;
    endtask

    task automatic test_thre_int;
        logic [7:0] d;
        busy_flag = 1'b0;
        wr(3'd1, 8'h02);
        wr(3'd0, 8'h11);
        rd(3'd2, d);
        checks++;
        if (d !== 8'h01) begin
            failures++;
            $display("FAIL thre_pend_iir got=%h exp=01", d);
        end
        idle(5);
        rd(3'd2, d);
        checks++;
        if (d !== 8'h02 || irq !== 1'b1) begin
            failures++;
            $display("FAIL thre_iir got=%h irq=%b exp=02 irq=1", d, irq);
        end
        rd(3'd2, d);
        checks++;
        if (d !== 8'h01 || irq !== 1'b0) begin
            failures++;
            $display("FAIL thre_clr got=%h irq=%b exp=01 irq=0", d, irq);
        end
    endtask

    task automatic test_scratch_rw;
        logic [7:0] d;
        wr(3'd7, 8'h5A);
        addr = 3'd7; wdata = 8'hC3; wr_en = 1'b1; rd_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        checks++;
        if (rdata !== 8'h5A) begin
            failures++;
            $display("FAIL scr_pre_write got=%h exp=5a", rdata);
        end
        rd(3'd7, d);
        checks++;
        if (d !== 8'hC3) begin
            failures++;
            $display("FAIL scr_post_write got=%h exp=c3", d);
        end
        wr(3'd4, 8'hFF);
        rd(3'd4, d);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("FAIL addr4 got=%h exp=00", d);
        end
    endtask

    task automatic test_reset_pend;
        logic [7:0] d;
        int base;
        busy_flag = 1'b1;
        wr(3'd0, 8'h77);
        base = wf_cnt;
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        busy_flag = 1'b0;
        idle(4);
        checks++;
        if (wf_cnt - base !== 0 || pi_tx_data !== 8'h00) begin
            failures++;
            $display("FAIL rst_pend got pulses=%0d data=%h exp=0 00", wf_cnt - base, pi_tx_data);
        end
        rd(3'd5, d);
        checks++;
        if (d !== 8'h60) begin
            failures++;
            $display("FAIL rst_pend_lsr got=%h exp=60", d);
        end
    endtask

    initial begin
        rst = 1'b1;
        addr = 3'd0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wdata = 8'h00;
        po_rx_data = 8'h00;
        parity_error = 1'b0;
        data_ready = 1'b0;
        busy_flag = 1'b0;
        @(negedge clk);
        test_reset;
        test_divisor;
        test_back_to_back;
        test_rx_read;
        test_parity;
        test_thre_int;
        test_scratch_rw;
        test_reset_pend;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
